// File: rtl/keypad_scanner_if.sv
// Keypad scanner pin and key-code bundle: row/col at the board pins,
// key/key_valid/key_held toward the display stage.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (input row, output col, key, key_valid, key_held);
    modport slave  (output row, input col, key, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot column drive, debounced press and
// release, one key_valid strobe per physical press, no rollover.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 1024,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);
    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t        state_q;
    logic [3:0]    row_s1_q, row_s_q;
    logic [3:0]    col_q;
    logic [SW-1:0] slot_q;
    logic [DW-1:0] cnt_q;
    logic [1:0]    row_idx_q, col_idx_q;
    logic [3:0]    key_q;
    logic          key_valid_q, key_held_q;
    logic          bit_s;

    function automatic logic [3:0] rot(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'd0:  return 4'h1;  4'd1:  return 4'h2;  4'd2:  return 4'h3;  4'd3:  return 4'hA;
            4'd4:  return 4'h4;  4'd5:  return 4'h5;  4'd6:  return 4'h6;  4'd7:  return 4'hB;
            4'd8:  return 4'h7;  4'd9:  return 4'h8;  4'd10: return 4'h9;  4'd11: return 4'hC;
            4'd12: return 4'hE;  4'd13: return 4'h0;  4'd14: return 4'hF;  default: return 4'hD;
        endcase
    endfunction

    // Only the latched row of the frozen column matters once a key is seen.
    assign bit_s = row_s_q[row_idx_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            row_s1_q    <= '0;
            row_s_q     <= '0;
            col_q       <= 4'b0001;
            slot_q      <= '0;
            cnt_q       <= '0;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_s1_q    <= kp.row;
            row_s_q     <= row_s1_q;
            key_valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (slot_q == SLOT_LAST) begin
                        slot_q <= '0;
                        // Sampling only at slot end gives the column time to settle.
                        if (|row_s_q) begin
                            row_idx_q <= low_idx(row_s_q);
                            col_idx_q <= low_idx(col_q);
                            cnt_q     <= '0;
                            state_q   <= DEBOUNCE;
                        end else begin
                            col_q <= rot(col_q);
                        end
                    end else begin
                        slot_q <= slot_q + SW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!bit_s) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        slot_q  <= '0;
                        col_q   <= rot(col_q);
                    end else if (cnt_q == DB_LAST) begin
                        state_q     <= HELD;
                        cnt_q       <= '0;
                        key_q       <= keymap(row_idx_q, col_idx_q);
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + DW'(1);
                    end
                end
                HELD: begin
                    if (bit_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q    <= SCAN;
                        cnt_q      <= '0;
                        slot_q     <= '0;
                        key_held_q <= 1'b0;
                        col_q      <= rot(col_q);
                    end else begin
                        cnt_q <= cnt_q + DW'(1);
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign kp.col       = col_q;
    assign kp.key       = key_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8;
// a keypad model drives row from col and the set of pressed keys.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pressed = '0;   // bit index r*4+c
    int          checks = 0;
    int          errors = 0;
    int          vcnt = 0;

    localparam logic [15:0] K1 = 16'h0001;  // r0 c0
    localparam logic [15:0] K5 = 16'h0020;  // r1 c1
    localparam logic [15:0] K6 = 16'h0040;  // r1 c2
    localparam logic [15:0] K9 = 16'h0400;  // r2 c2
    localparam logic [15:0] KD = 16'h8000;  // r3 c3

    keypad_scanner_if kif ();

    assign kif.row = {|(pressed[15:12] & kif.col), |(pressed[11:8] & kif.col),
                      |(pressed[7:4] & kif.col),   |(pressed[3:0] & kif.col)};

    keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (kif.key_valid === 1'b1) vcnt++;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_col(input logic [3:0] c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (kif.col === c) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; pressed = '0;
        step(2);
        checks++; if (kif.col !== 4'b0001) begin errors++; $display("FAIL rst_col got %b exp 0001", kif.col); end
        checks++; if (kif.key !== 4'h0) begin errors++; $display("FAIL rst_key got %h exp 0", kif.key); end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL rst_kv got %b exp 0", kif.key_valid); end
        checks++; if (kif.key_held !== 1'b0) begin errors++; $display("FAIL rst_kh got %b exp 0", kif.key_held); end
        reset = 1'b1;
        step(3);
        checks++; if (kif.col !== 4'b0001) begin errors++; $display("FAIL scan_c3 got %b exp 0001", kif.col); end
        step(1);
        checks++; if (kif.col !== 4'b0010) begin errors++; $display("FAIL scan_c4 got %b exp 0010", kif.col); end
        step(4);
        checks++; if (kif.col !== 4'b0100) begin errors++; $display("FAIL scan_c8 got %b exp 0100", kif.col); end
        step(4);
        checks++; if (kif.col !== 4'b1000) begin errors++; $display("FAIL scan_c12 got %b exp 1000", kif.col); end
        step(4);
        checks++; if (kif.col !== 4'b0001) begin errors++; $display("FAIL scan_c16 got %b exp 0001", kif.col); end
        checks++; if (vcnt != 0 || kif.key_held !== 1'b0) begin errors++; $display("FAIL scan_idle got vcnt %0d kh %b exp 0 0", vcnt, kif.key_held); end
    endtask

    task automatic test_bounce;
        bit ok;
        wait_col(4'b1000, ok);
        pressed = K1;
        wait_col(4'b0001, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bounce_wait got timeout exp col 0001"); end
        step(4);
        checks++; if (kif.col !== 4'b0001) begin errors++; $display("FAIL bounce_freeze got %b exp 0001", kif.col); end
        pressed = '0;
        step(2);
        checks++; if (kif.col !== 4'b0001) begin errors++; $display("FAIL bounce_hold got %b exp 0001", kif.col); end
        step(1);
        checks++; if (kif.col !== 4'b0010) begin errors++; $display("FAIL bounce_resume got %b exp 0010", kif.col); end
        checks++; if (kif.key !== 4'h0 || vcnt != 0 || kif.key_held !== 1'b0) begin
            errors++; $display("FAIL bounce_nokey got key %h vcnt %0d kh %b exp 0 0 0", kif.key, vcnt, kif.key_held); end
    endtask

    task automatic test_clean_press;
        bit ok;
        wait_col(4'b0010, ok);
        pressed = K6;
        wait_col(4'b0100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL press6_wait got timeout exp col 0100"); end
        step(4);
        checks++; if (kif.col !== 4'b0100) begin errors++; $display("FAIL press6_freeze got %b exp 0100", kif.col); end
        step(7);
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL press6_early got kv %b exp 0", kif.key_valid); end
        step(1);
        checks++; if (kif.key_valid !== 1'b1 || kif.key !== 4'h6 || kif.key_held !== 1'b1) begin
            errors++; $display("FAIL press6_strobe got kv %b key %h kh %b exp 1 6 1", kif.key_valid, kif.key, kif.key_held); end
        step(1);
        checks++; if (kif.key_valid !== 1'b0 || kif.key_held !== 1'b1 || vcnt != 1) begin
            errors++; $display("FAIL press6_single got kv %b kh %b vcnt %0d exp 0 1 1", kif.key_valid, kif.key_held, vcnt); end
        pressed = '0;
        step(9);
        checks++; if (kif.key_held !== 1'b1) begin errors++; $display("FAIL rel6_early got kh %b exp 1", kif.key_held); end
        step(1);
        checks++; if (kif.key_held !== 1'b0 || kif.col !== 4'b1000) begin
            errors++; $display("FAIL rel6_done got kh %b col %b exp 0 1000", kif.key_held, kif.col); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        wait_col(4'b1000, ok);
        pressed = K5;
        wait_col(4'b0010, ok);
        checks++; if (!ok) begin errors++; $display("FAIL press5_wait got timeout exp col 0010"); end
        step(12);
        checks++; if (kif.key_valid !== 1'b1 || kif.key !== 4'h5) begin
            errors++; $display("FAIL press5_strobe got kv %b key %h exp 1 5", kif.key_valid, kif.key); end
        pressed = K5 | K9;
        step(20);
        checks++; if (vcnt != 2 || kif.key !== 4'h5 || kif.key_held !== 1'b1 || kif.col !== 4'b0010) begin
            errors++; $display("FAIL hold59 got vcnt %0d key %h kh %b col %b exp 2 5 1 0010", vcnt, kif.key, kif.key_held, kif.col); end
        pressed = '0;
        step(9);
        checks++; if (kif.key_held !== 1'b1) begin errors++; $display("FAIL rel59_early got kh %b exp 1", kif.key_held); end
        step(1);
        checks++; if (kif.key_held !== 1'b0 || kif.col !== 4'b0100) begin
            errors++; $display("FAIL rel59_done got kh %b col %b exp 0 0100", kif.key_held, kif.col); end
        pressed = K9;
        step(11);
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL press9_early got kv %b exp 0", kif.key_valid); end
        step(1);
        checks++; if (kif.key_valid !== 1'b1 || kif.key !== 4'h9 || vcnt != 3) begin
            errors++; $display("FAIL press9_strobe got kv %b key %h vcnt %0d exp 1 9 3", kif.key_valid, kif.key, vcnt); end
    endtask

    task automatic test_release_glitch;
        step(2);
        pressed = '0;
        step(5);
        pressed = K9;
        step(1);
        pressed = '0;
        step(4);
        checks++; if (kif.key_held !== 1'b1) begin errors++; $display("FAIL glitch_mid got kh %b exp 1", kif.key_held); end
        step(5);
        checks++; if (kif.key_held !== 1'b1) begin errors++; $display("FAIL glitch_late got kh %b exp 1", kif.key_held); end
        step(1);
        checks++; if (kif.key_held !== 1'b0 || kif.col !== 4'b1000 || vcnt != 3) begin
            errors++; $display("FAIL glitch_done got kh %b col %b vcnt %0d exp 0 1000 3", kif.key_held, kif.col, vcnt); end
    endtask

    task automatic test_reset_mid_debounce;
        bit ok;
        wait_col(4'b0100, ok);
        pressed = KD;
        wait_col(4'b1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pressD_wait got timeout exp col 1000"); end
        step(7);
        checks++; if (kif.col !== 4'b1000) begin errors++; $display("FAIL pressD_freeze got %b exp 1000", kif.col); end
        step(1);
        reset = 1'b0;
        #1;
        checks++; if (kif.col !== 4'b0001 || kif.key !== 4'h0 || kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin
            errors++; $display("FAIL midrst_out got col %b key %h kv %b kh %b exp 0001 0 0 0",
                               kif.col, kif.key, kif.key_valid, kif.key_held); end
        pressed = '0;
        step(2);
        reset = 1'b1;
        step(30);
        checks++; if (vcnt != 3 || kif.key !== 4'h0 || kif.key_held !== 1'b0) begin
            errors++; $display("FAIL midrst_after got vcnt %0d key %h kh %b exp 3 0 0", vcnt, kif.key, kif.key_held); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_back_to_back();
        test_release_glitch();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad by driving one column at a time and sampling the row lines, debounces the result, and emits one hex key code per physical press. It sits directly upstream of the two-digit display logic in `top`. It owns the `col` outputs and the `row` inputs at the board pins. It hands the display stage a single-cycle `key_valid` strobe with the 4-bit `key` code. No rollover: one key is reported per press, and it must be released before the next is accepted.

## Interface
- SCAN_CYCLES, 1024: clock cycles each column stays driven; minimum 4.
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required to accept a press or a release; minimum 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- row  in  4  raw row lines, active-high (1 = key in driven column pressed), asynchronous to clk.
- col  out  4  one-hot active-high column drive.
- key  out  4  hex code of last accepted key; holds until the next accept.
- key_valid  out  1  one-cycle strobe: `key` was just updated.
- key_held  out  1  high while an accepted key is still pressed or not yet release-debounced.

## Operation
- `row` passes through a 2-flop synchronizer (`row_s`) before any use.
- Key map, given as row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
  - c0 is the leftmost column.
- FSM states:
  - SCAN
    - The slot counter counts 0..SCAN_CYCLES-1, then wraps.
    - On wrap, `col` rotates left: 0001→0010→0100→1000→0001.
    - `row_s` is sampled only at counter == SCAN_CYCLES-1, which is the settle margin.
    - If the sample is nonzero: latch the column index and the lowest-index set row bit, freeze `col`, clear the debounce counter, and go to DEBOUNCE.
  - DEBOUNCE
    - While the latched `row_s` bit = 1, the counter increments.
    - If the bit = 0 at any cycle: return to SCAN, counter cleared, and `col` advances to the next column. No strobe.
    - When counter == DEBOUNCE_CYCLES-1 and the bit = 1: go to HELD. On the next cycle `key` is loaded from the map and `key_valid` = 1 for exactly one cycle.
  - HELD
    - `col` stays frozen and `key_held` = 1.
    - The release counter increments while the latched bit = 0, and clears whenever the bit = 1.
    - When it reaches DEBOUNCE_CYCLES-1: go to SCAN, `key_held` = 0, `col` advances to the next column.
    - Other rows and columns are ignored.
- Multiple row bits set at detection: the lowest index wins. Additional presses in the same column are ignored.
- Counter widths: $clog2 of the parameter. Counters saturate and never wrap inside DEBOUNCE or HELD.

## Timing
- Reset values (asynchronous, immediate on reset = 0):
  - `col` = 0001
  - `key` = 0
  - `key_valid` = 0
  - `key_held` = 0
  - state SCAN
  - all counters and synchronizer flops = 0
- First column rotation occurs SCAN_CYCLES cycles after reset deasserts.
- A `row` edge reaches `row_s` 2 cycles later.
- Press latency, from the SCAN sample cycle to `key_valid`: DEBOUNCE_CYCLES + 1 cycles, assuming the row bit is stable.
- `key_valid` never asserts twice for one press, and never asserts in the same cycle as reset.
- `key_held` rises in the same cycle as `key_valid`. It falls DEBOUNCE_CYCLES cycles after the last latched-bit 1 in HELD (± sync latency).
- Reset asserted mid-DEBOUNCE or mid-HELD: no strobe is emitted, and all outputs take their reset values.
- `col` changes only on slot wrap in SCAN, or on a DEBOUNCE/HELD → SCAN transition. Never more than one bit is high.

## Test plan
Bench parameters: SCAN_CYCLES=4, DEBOUNCE_CYCLES=8. The bench keypad model drives `row` = f(`col`, pressed set).
- Reset/scan: hold reset = 0 for 2 cycles, then release with no keys → `col` = 0001 at release, 0010 after 4 cycles, full cycle back to 0001 after 16; `key_valid` and `key_held` stay 0.
- Clean press: press key "6" (r1,c2) → `col` freezes at 0100; exactly one `key_valid` pulse with `key` = 6, 9 cycles after the sample; `key_held` = 1.
- Bounce rejection: "1" (r0,c0) high for 3 cycles then released → no `key_valid`, `key` stays 0, scanning resumes at `col` = 0010.
- Hold plus second key: press "5", then also "9" while held → a single pulse, `key` = 5. Release both → `key_held` = 0 after 8 stable cycles. Press "9" → second pulse with `key` = 9.
- Release glitch: in HELD, release for 5 cycles, re-press for 1 cycle, release → `key_held` falls only after 8 contiguous released cycles; no new `key_valid`.
- Reset mid-DEBOUNCE: press "D" (r3,c3), assert reset at debounce count 4 → outputs immediately return to reset values; no `key_valid` ever observed.
